// File: rtl/xadc_scan_ctrl.sv
// xadc_scan_ctrl: walks a channel range through the XADC DRP reader,
// averages 2^k samples per channel and streams {ch, avg, err}.
module xadc_scan_ctrl #(
    parameter int START_CYCLES = 4,
    parameter int GAP_CYCLES   = 64,
    parameter int TIMEOUT_CYC  = 65535,
    parameter int MAX_AVG_LOG2 = 4
) (
    input  logic        clk200,
    input  logic        rst_n,
    input  logic        scan_start,
    input  logic        scan_abort,
    input  logic        continuous,
    input  logic [4:0]  first_ch,
    input  logic [5:0]  num_ch,
    input  logic [2:0]  avg_log2,
    output logic        rd_start,
    output logic [4:0]  rd_ch_sel,
    input  logic        rd_done,
    input  logic [11:0] rd_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_ch,
    output logic [11:0] out_data,
    output logic        out_err,
    output logic        busy,
    output logic        scan_done
);
    localparam int AW = 12 + MAX_AVG_LOG2;
    localparam int CW = MAX_AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + GAP_CYCLES + START_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_GAP, S_EMIT, S_NEXT
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tmr;
    logic [4:0]    ch, first_q;
    logic [5:0]    nch_q, idx;
    logic [2:0]    avg_q;
    logic          cont_q;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          err;
    logic          abort_pend;
    logic          done_q;

    logic [2:0]    avg_in;
    logic [5:0]    nch_in;
    logic [CW-1:0] cnt_max;
    logic          req_end, gap_end, tmo;
    logic          sample_evt, last_sample, last_ch;

    assign avg_in      = (avg_log2 > 3'(MAX_AVG_LOG2)) ? 3'(MAX_AVG_LOG2) : avg_log2;
    assign nch_in      = (num_ch == 6'd0) ? 6'd1 : num_ch;
    assign cnt_max     = (CW'(1) << avg_q) - CW'(1);
    assign req_end     = (tmr == TW'(START_CYCLES - 1));
    assign gap_end     = (tmr == TW'(GAP_CYCLES));
    assign tmo         = (tmr == TW'(TIMEOUT_CYC - 1));
    assign sample_evt  = (state == S_WAIT) && (rd_done || tmo);
    assign last_sample = (cnt == cnt_max);
    assign last_ch     = (idx == nch_q - 6'd1);

    // State register
    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state decode; an abort is only taken where no request is open
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (scan_start) state_n = S_GAP;
            S_GAP: begin
                if (abort_pend)   state_n = S_IDLE;
                else if (gap_end) state_n = S_REQ;
            end
            S_REQ:  if (req_end) state_n = S_WAIT;
            S_WAIT: if (sample_evt) state_n = last_sample ? S_EMIT : S_GAP;
            S_EMIT: if (out_ready) state_n = S_NEXT;
            S_NEXT: begin
                if (abort_pend || (last_ch && !cont_q)) state_n = S_IDLE;
                else                                   state_n = S_GAP;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs decoded from state; beat fields are zero outside EMIT
    always_comb begin
        rd_start  = (state == S_REQ);
        rd_ch_sel = ch;
        out_valid = (state == S_EMIT);
        out_ch    = (state == S_EMIT) ? ch : 5'd0;
        out_data  = (state == S_EMIT) ? 12'(acc >> avg_q) : 12'd0;
        out_err   = (state == S_EMIT) ? err : 1'b0;
        busy      = (state != S_IDLE);
        scan_done = done_q;
    end

    // Shared phase timer: start width, reader timeout and settling gap
    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (state_n != state)
            tmr <= '0;
        else if (state == S_REQ || state == S_WAIT || state == S_GAP)
            tmr <= tmr + TW'(1);
    end

    // Scan config, channel walk and per-channel accumulation
    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= '0;
            first_q <= '0;
            nch_q   <= '0;
            idx     <= '0;
            avg_q   <= '0;
            cont_q  <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (scan_start) begin
                    ch      <= first_ch;
                    first_q <= first_ch;
                    nch_q   <= nch_in;
                    idx     <= '0;
                    avg_q   <= avg_in;
                    cont_q  <= continuous;
                    acc     <= '0;
                    cnt     <= '0;
                    err     <= 1'b0;
                end
                S_WAIT: if (sample_evt) begin
                    cnt <= cnt + CW'(1);
                    if (rd_done) acc <= acc + AW'(rd_result);
                    else         err <= 1'b1;
                end
                S_NEXT: begin
                    acc <= '0;
                    cnt <= '0;
                    err <= 1'b0;
                    if (last_ch) begin
                        ch  <= first_q;
                        idx <= '0;
                    end else begin
                        ch  <= ch + 5'd1;
                        idx <= idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pending abort flag and the end-of-scan pulse
    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            abort_pend <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (state == S_IDLE)  abort_pend <= 1'b0;
            else if (scan_abort)  abort_pend <= 1'b1;
            done_q <= (state != S_IDLE) && (state_n == S_IDLE);
        end
    end

endmodule
